// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: takes bitstream bytes over a valid/ready
// handshake, serializes them onto the head of the configuration flop chain,
// counts shifted bits against the chain length and watches the chain tail,
// which must still show its reset contents (all 0) while the load runs.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 64,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       prog_clk,
  input  logic       pReset,
  input  logic       start,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  input  logic       ccff_tail,
  output logic       cfg_done,
  output logic       cfg_err
);

  localparam int CntW = $clog2(CHAIN_LEN + 1);
  localparam logic [CntW-1:0] LenC = CntW'(CHAIN_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic [2:0]      idx_q;
  logic [7:0]      sreg_q;
  logic            ready_q;
  logic            head_q;
  logic            shiftEn_q;
  logic            done_q;
  logic            err_q;

  logic            firstBit;
  logic            nextBit;
  logic [7:0]      dataShifted;
  logic [7:0]      sregShifted;

  // Bit ordering helpers: the shift register always holds the not-yet-sent
  // bits of the current byte, aligned so the next one sits at the exit end.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (MSB_FIRST) begin
      firstBit    = cfg_data[7];
      nextBit     = sreg_q[7];
      dataShifted = {cfg_data[6:0], 1'b0};
      sregShifted = {sreg_q[6:0], 1'b0};
    end else begin
      firstBit    = cfg_data[0];
      nextBit     = sreg_q[0];
      dataShifted = {1'b0, cfg_data[7:1]};
      sregShifted = {1'b0, sreg_q[7:1]};
    end
  end

  // Loader FSM: every output is a register updated here, so the chain sees
  // glitch-free head/shift_en and a shift edge is exactly one where shift_en=1.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sreg_q    <= '0;
      ready_q   <= 1'b0;
      head_q    <= 1'b0;
      shiftEn_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_q   <= ST_WAIT;
            cnt_q     <= '0;
            idx_q     <= '0;
            ready_q   <= 1'b1;
            head_q    <= 1'b0;
            shiftEn_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (cfg_valid && ready_q) begin
            state_q   <= ST_SHIFT;
            sreg_q    <= dataShifted;
            head_q    <= firstBit;
            shiftEn_q <= 1'b1;
            ready_q   <= 1'b0;
            idx_q     <= '0;
          end
        end

        ST_SHIFT: begin
          // The chain captures head on this edge, so one more bit is in.
          cnt_q <= cnt_d;
          if (ccff_tail) begin
            state_q   <= ST_ERR;
            err_q     <= 1'b1;
            shiftEn_q <= 1'b0;
            head_q    <= 1'b0;
          end else if (cnt_d == LenC) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            shiftEn_q <= 1'b0;
            head_q    <= 1'b0;
          end else if (idx_q == 3'd7) begin
            state_q   <= ST_WAIT;
            ready_q   <= 1'b1;
            shiftEn_q <= 1'b0;
            head_q    <= 1'b0;
          end else begin
            idx_q  <= idx_q + 3'd1;
            head_q <= nextBit;
            sreg_q <= sregShifted;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          ready_q   <= 1'b0;
          shiftEn_q <= 1'b0;
          head_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready     = ready_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shiftEn_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: three instances (16 bits MSB-first,
// 12 bits MSB-first, 20 bits LSB-first) loaded with directed and random
// bitstreams; a monitor logs every shifted head bit and drives the tail.
module tb_ccff_bitstream_loader;

  bit         clk;
  bit         rst;
  bit         startV[3];
  bit   [7:0] dataV[3];
  bit         validV[3];
  bit         tailV[3];
  logic       readyV[3];
  logic       headV[3];
  logic       shEnV[3];
  logic       doneV[3];
  logic       errV[3];

  int         cyc;
  int         errors;
  int         checks;

  int         shiftCnt[3];
  bit         headLog[3][0:4095];
  int         lastShiftCyc[3];
  int         doneRiseCyc[3];
  int         errRiseCyc[3];
  bit         prevDone[3];
  bit         prevErr[3];
  int         errAbs[3];

  logic [7:0] stim[0:7];

  ccff_bitstream_loader #(.CHAIN_LEN(16), .MSB_FIRST(1'b1)) dut0 (
    .prog_clk(clk), .pReset(rst), .start(startV[0]), .cfg_data(dataV[0]),
    .cfg_valid(validV[0]), .cfg_ready(readyV[0]), .ccff_head(headV[0]),
    .ccff_shift_en(shEnV[0]), .ccff_tail(tailV[0]), .cfg_done(doneV[0]),
    .cfg_err(errV[0])
  );

  ccff_bitstream_loader #(.CHAIN_LEN(12), .MSB_FIRST(1'b1)) dut1 (
    .prog_clk(clk), .pReset(rst), .start(startV[1]), .cfg_data(dataV[1]),
    .cfg_valid(validV[1]), .cfg_ready(readyV[1]), .ccff_head(headV[1]),
    .ccff_shift_en(shEnV[1]), .ccff_tail(tailV[1]), .cfg_done(doneV[1]),
    .cfg_err(errV[1])
  );

  ccff_bitstream_loader #(.CHAIN_LEN(20), .MSB_FIRST(1'b0)) dut2 (
    .prog_clk(clk), .pReset(rst), .start(startV[2]), .cfg_data(dataV[2]),
    .cfg_valid(validV[2]), .cfg_ready(readyV[2]), .ccff_head(headV[2]),
    .ccff_shift_en(shEnV[2]), .ccff_tail(tailV[2]), .cfg_done(doneV[2]),
    .cfg_err(errV[2])
  );

  // Free-running programming clock.
  always #5 clk = ~clk;

  // Cycle number, used to time done/err against the last shift.
  always @(posedge clk) cyc <= cyc + 1;

  // Chain model: logs each shift pulse, and holds the tail at 1 from the
  // chosen faulty shift onward to emulate a chain that is not all-zero.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      tailV[s] = (errAbs[s] >= 0) && (shiftCnt[s] >= errAbs[s]);
      if (shEnV[s] === 1'b1) begin
        if (shiftCnt[s] < 4096) headLog[s][shiftCnt[s]] = headV[s];
        shiftCnt[s]++;
        lastShiftCyc[s] = cyc;
      end
      if (doneV[s] === 1'b1 && !prevDone[s]) doneRiseCyc[s] = cyc;
      if (errV[s] === 1'b1 && !prevErr[s]) errRiseCyc[s] = cyc;
      prevDone[s] = (doneV[s] === 1'b1);
      prevErr[s]  = (errV[s] === 1'b1);
    end
  end

  function automatic int lenOf(input int s);
    return (s == 0) ? 16 : (s == 1) ? 12 : 20;
  endfunction

  function automatic bit msbOf(input int s);
    return (s != 2);
  endfunction

  // Reference: bit j of the stream comes from byte j/8, taken from the top
  // or the bottom of that byte depending on the instance's bit order.
  function automatic bit expBit(input int s, input int j);
    logic [7:0] b;
    b = stim[j / 8];
    if (msbOf(s)) return b[3'(7 - (j % 8))];
    return b[3'(j % 8)];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One complete load on instance s. errAt<0 means a healthy chain,
  // otherwise the tail reads 1 on shift number errAt (0-based).
  task automatic applyStimulus(input int s, input int errAt, input bit pokeStart);
    int L;
    int need;
    int base;
    int guard;
    int rdy;
    int expShifts;
    int endCyc;
    logic [63:0] obs;
    logic [63:0] exp;
    L    = lenOf(s);
    need = (L + 7) / 8;
    base = shiftCnt[s];
    errAbs[s] = (errAt >= 0) ? base + errAt : -1;

    startV[s] = 1'b1;
    tick();
    startV[s] = 1'b0;
    checkOutput("startReady", 64'(readyV[s]), 64'd1);
    checkOutput("startDoneClr", 64'(doneV[s]), 64'd0);
    checkOutput("startErrClr", 64'(errV[s]), 64'd0);

    for (int i = 0; i < need; i++) begin
      dataV[s]  = stim[i];
      validV[s] = 1'b1;
      if (readyV[s] !== 1'b1) begin
        checkOutput("offerReady", 64'(readyV[s]), 64'd1);
        break;
      end
      tick();
      // Keep offering: the next byte (or a surplus one) sits on the bus
      // while the current byte shifts out.
      dataV[s] = (i + 1 < need) ? stim[i + 1] : 8'($urandom);
      guard = 0;
      while (readyV[s] !== 1'b1 && doneV[s] !== 1'b1 && errV[s] !== 1'b1 && guard < 40) begin
        guard++;
        startV[s] = pokeStart && (guard == 3);
        tick();
      end
      startV[s] = 1'b0;
      if (errV[s] === 1'b1 || doneV[s] === 1'b1) break;
      checkOutput("readyGap", 64'(guard), 64'd8);
    end

    rdy = 0;
    repeat (6) begin
      tick();
      if (readyV[s] === 1'b1) rdy++;
    end
    validV[s] = 1'b0;
    checkOutput("noAcceptAfterEnd", 64'(rdy), 64'd0);

    expShifts = (errAt >= 0) ? errAt + 1 : L;
    checkOutput("shiftCount", 64'(shiftCnt[s] - base), 64'(expShifts));
    checkOutput("doneFlag", 64'(doneV[s]), 64'(errAt < 0));
    checkOutput("errFlag", 64'(errV[s]), 64'(errAt >= 0));
    endCyc = (errAt >= 0) ? errRiseCyc[s] : doneRiseCyc[s];
    checkOutput("endTiming", 64'(endCyc - lastShiftCyc[s]), 64'd1);

    obs = '0;
    exp = '0;
    for (int j = 0; j < expShifts && j < 64; j++) begin
      obs[j] = headLog[s][base + j];
      exp[j] = expBit(s, j);
    end
    checkOutput("headSeq", obs, exp);
    errAbs[s] = -1;
  endtask

  // Directed cases first, then random loads across all three instances.
  initial begin
    int base;
    int guard;
    int c;
    int s;
    int errAt;
    bit poke;
    for (int k = 0; k < 3; k++) errAbs[k] = -1;
    rst = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 3; k++)
      checkOutput("resetOut", 64'({readyV[k], headV[k], shEnV[k], doneV[k], errV[k]}), 64'd0);
    rst = 1'b0;
    tick();

    stim[0] = 8'hA5; stim[1] = 8'h3C;
    applyStimulus(0, -1, 1'b0);

    stim[0] = 8'hFF; stim[1] = 8'hF0;
    applyStimulus(1, -1, 1'b0);

    stim[0] = 8'h00; stim[1] = 8'h00;
    applyStimulus(0, 0, 1'b0);

    // Reset in the middle of a byte, after three shifts.
    base = shiftCnt[0];
    startV[0] = 1'b1;
    tick();
    startV[0] = 1'b0;
    dataV[0]  = 8'hC3;
    validV[0] = 1'b1;
    tick();
    validV[0] = 1'b0;
    guard = 0;
    while (shiftCnt[0] - base < 3 && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("preResetShifts", 64'(shiftCnt[0] - base), 64'd3);
    rst = 1'b1;
    #1;
    checkOutput("resetImmediate", 64'({readyV[0], headV[0], shEnV[0], doneV[0], errV[0]}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    c = shiftCnt[0];
    repeat (10) tick();
    checkOutput("noShiftAfterReset", 64'(shiftCnt[0] - c), 64'd0);
    checkOutput("idleReady", 64'(readyV[0]), 64'd0);

    stim[0] = 8'h3A; stim[1] = 8'h55;
    applyStimulus(0, -1, 1'b1);

    for (int it = 0; it < 20; it++) begin
      s = int'($urandom_range(0, 2));
      for (int k = 0; k < 8; k++) stim[k] = 8'($urandom);
      errAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lenOf(s) - 1)) : -1;
      poke  = 1'($urandom_range(0, 1));
      applyStimulus(s, errAt, poke);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
